// File: rtl/i2c_burst_master.sv
// I2C master that runs one burst command (device, memory address, length, direction)
// as START / address / data / STOP bit slots, each CLK_DIV system clocks long.
module i2c_burst_master #(
    parameter int DEV_ADDR_W = 7,
    parameter int MEM_ADDR_W = 8,
    parameter int MAX_BURST  = 4,
    parameter int CLK_DIV    = 8,
    parameter int LEN_W      = $clog2(MAX_BURST + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ce,
    input  logic                   wren,
    input  logic                   rden,
    input  logic [DEV_ADDR_W-1:0]  dev_addr,
    input  logic [MEM_ADDR_W-1:0]  mem_addr,
    input  logic [LEN_W-1:0]       len,
    input  logic [8*MAX_BURST-1:0] wdata,
    output logic [8*MAX_BURST-1:0] rdata,
    output logic                   ready,
    output logic                   done,
    output logic                   error,
    output logic                   SCL,
    output logic                   sda_oe,
    input  logic                   sda_in
);
    localparam int A  = MEM_ADDR_W / 8;
    localparam int PW = $clog2(CLK_DIV);
    localparam int CW = $clog2(MAX_BURST + A + 1);
    localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] P_HALF = PW'(CLK_DIV / 2);
    localparam logic [PW-1:0] P_Q3   = PW'(3 * CLK_DIV / 4);
    localparam logic [CW-1:0] A_LAST = CW'(A - 1);

    typedef enum logic [3:0] {
        IDLE, START, DEV, DEV_ACK, MADDR, MADDR_ACK, WBYTE, WACK,
        RSTART, DEVR, DEVR_ACK, RBYTE, MACK, STOP
    } state_t;

    state_t                  state, nxt_state;
    logic [PW-1:0]           phase, nxt_phase;
    logic [2:0]              bit_cnt, nxt_bit;
    logic [CW-1:0]           byte_cnt, nxt_byte, len_last;
    logic [7:0]              tx, nxt_tx, rx;
    logic [MEM_ADDR_W-1:0]   mem_sh, nxt_mem_sh;
    logic [8*MAX_BURST-1:0]  wdata_sh, nxt_wdata_sh;
    logic [DEV_ADDR_W-1:0]   dev_q;
    logic                    rd_q, ack_smp;

    wire slot_end  = (phase == P_LAST);
    wire illegal   = (wren == rden) || (len == '0) || (len > LEN_W'(MAX_BURST));
    wire accept    = ce && (state == IDLE) && !illegal;
    wire reject    = ce && (state == IDLE) && illegal;
    wire ack_state = (state == DEV_ACK) || (state == MADDR_ACK) || (state == WACK) || (state == DEVR_ACK);

    function automatic logic scl_of(state_t s, logic [PW-1:0] p);
        return (s == IDLE || s == START) ? 1'b1 : (p >= P_HALF);
    endfunction

    // Pull-down enable for the slot phase being entered; slave-owned slots release.
    function automatic logic sda_of(state_t s, logic [PW-1:0] p, logic bit_out, logic last);
        case (s)
            START:                   return p >= P_HALF;
            RSTART:                  return p >= P_Q3;
            STOP:                    return p < P_Q3;
            DEV, MADDR, WBYTE, DEVR: return !bit_out;
            MACK:                    return !last;
            default:                 return 1'b0;
        endcase
    endfunction

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        nxt_state    = state;
        nxt_phase    = (state == IDLE || slot_end) ? '0 : phase + 1'b1;
        nxt_bit      = bit_cnt;
        nxt_byte     = byte_cnt;
        nxt_tx       = tx;
        nxt_mem_sh   = mem_sh;
        nxt_wdata_sh = wdata_sh;
        if (state == IDLE) begin
            if (accept) begin
                nxt_state    = START;
                nxt_mem_sh   = mem_addr;
                nxt_wdata_sh = wdata;
                nxt_bit      = '0;
                nxt_byte     = '0;
            end
        end else if (slot_end) begin
            case (state)
                START: begin
                    nxt_state = DEV;
                    nxt_tx    = {dev_q, 1'b0};
                end
                DEV, MADDR, WBYTE, DEVR, RBYTE: begin
                    if (bit_cnt == 3'd7) begin
                        nxt_bit = '0;
                        case (state)
                            DEV:     nxt_state = DEV_ACK;
                            MADDR: begin
                                nxt_state  = MADDR_ACK;
                                nxt_mem_sh = mem_sh << 8;
                            end
                            WBYTE: begin
                                nxt_state    = WACK;
                                nxt_wdata_sh = wdata_sh >> 8;
                            end
                            DEVR:    nxt_state = DEVR_ACK;
                            default: nxt_state = MACK;
                        endcase
                    end else begin
                        nxt_bit = bit_cnt + 1'b1;
                        nxt_tx  = tx << 1;
                    end
                end
                DEV_ACK: begin
                    if (ack_smp) nxt_state = STOP;
                    else begin
                        nxt_state = MADDR;
                        nxt_tx    = mem_sh[MEM_ADDR_W-1 -: 8];
                        nxt_byte  = '0;
                    end
                end
                MADDR_ACK: begin
                    if (ack_smp) nxt_state = STOP;
                    else if (byte_cnt == A_LAST) begin
                        nxt_byte  = '0;
                        nxt_state = rd_q ? RSTART : WBYTE;
                        nxt_tx    = wdata_sh[7:0];
                    end else begin
                        nxt_byte  = byte_cnt + 1'b1;
                        nxt_state = MADDR;
                        nxt_tx    = mem_sh[MEM_ADDR_W-1 -: 8];
                    end
                end
                WACK: begin
                    if (ack_smp || byte_cnt == len_last) nxt_state = STOP;
                    else begin
                        nxt_byte  = byte_cnt + 1'b1;
                        nxt_state = WBYTE;
                        nxt_tx    = wdata_sh[7:0];
                    end
                end
                RSTART: begin
                    nxt_state = DEVR;
                    nxt_tx    = {dev_q, 1'b1};
                end
                DEVR_ACK: nxt_state = ack_smp ? STOP : RBYTE;
                MACK: begin
                    if (byte_cnt == len_last) nxt_state = STOP;
                    else begin
                        nxt_byte  = byte_cnt + 1'b1;
                        nxt_state = RBYTE;
                    end
                end
                default: nxt_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            phase    <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            tx       <= '0;
            rx       <= '0;
            mem_sh   <= '0;
            wdata_sh <= '0;
            dev_q    <= '0;
            rd_q     <= 1'b0;
            len_last <= '0;
            ack_smp  <= 1'b0;
            rdata    <= '0;
            ready    <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            SCL      <= 1'b1;
            sda_oe   <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
            state    <= nxt_state;
            phase    <= nxt_phase;
            bit_cnt  <= nxt_bit;
            byte_cnt <= nxt_byte;
            tx       <= nxt_tx;
            mem_sh   <= nxt_mem_sh;
            wdata_sh <= nxt_wdata_sh;
            // Bus pins are registered from the slot being entered, so they line up with phase.
            SCL      <= scl_of(nxt_state, nxt_phase);
            sda_oe   <= sda_of(nxt_state, nxt_phase, nxt_tx[7], nxt_byte == len_last);
            ready    <= (nxt_state == IDLE);
            done     <= reject || (state == STOP && nxt_state == IDLE);
            if (ce && state == IDLE) error <= illegal;
            if (accept) begin
                dev_q    <= dev_addr;
                rd_q     <= rden;
                len_last <= CW'(len) - CW'(1);
            end
            if (phase == P_Q3) begin
                ack_smp <= sda_in;
                if (state == RBYTE) rx <= {rx[6:0], sda_in};
            end
            if (slot_end && ack_state && ack_smp) error <= 1'b1;
            if (slot_end && state == MACK) rdata[8*byte_cnt +: 8] <= rx;
        end
    end
endmodule

// File: tb/tb_i2c_burst_master.sv
// Drives two masters (1- and 2-byte memory address) onto one bus with a behavioural
// I2C memory slave; bus events are decoded and scored against an expected-token queue.
module tb_i2c_burst_master;
    localparam logic [11:0] TK_START  = 12'h100;
    localparam logic [11:0] TK_RSTART = 12'h200;
    localparam logic [11:0] TK_STOP   = 12'h300;
    localparam logic [11:0] TK_MACK   = 12'h400;
    localparam logic [6:0]  SLV       = 7'h01;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        ce8 = 1'b0, ce16 = 1'b0, wren = 1'b0, rden = 1'b0;
    logic [6:0]  dev = '0;
    logic [7:0]  mem8 = '0;
    logic [15:0] mem16 = '0;
    logic [2:0]  len = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata8, rdata16;
    logic        ready8, ready16, done8, done16, error8, error16;
    logic        scl8, scl16, sda_oe8, sda_oe16;
    logic        slave_low = 1'b0;
    logic        scl_bus, sda_bus;
    assign scl_bus = scl8 & scl16;
    assign sda_bus = ~(sda_oe8 | sda_oe16 | slave_low);

    i2c_burst_master #(.MEM_ADDR_W(8), .MAX_BURST(4), .CLK_DIV(8)) dut8 (
        .clk(clk), .reset(reset), .ce(ce8), .wren(wren), .rden(rden), .dev_addr(dev),
        .mem_addr(mem8), .len(len), .wdata(wdata), .rdata(rdata8), .ready(ready8),
        .done(done8), .error(error8), .SCL(scl8), .sda_oe(sda_oe8), .sda_in(sda_bus));

    i2c_burst_master #(.MEM_ADDR_W(16), .MAX_BURST(4), .CLK_DIV(8)) dut16 (
        .clk(clk), .reset(reset), .ce(ce16), .wren(wren), .rden(rden), .dev_addr(dev),
        .mem_addr(mem16), .len(len), .wdata(wdata), .rdata(rdata16), .ready(ready16),
        .done(done16), .error(error16), .SCL(scl16), .sda_oe(sda_oe16), .sda_in(sda_bus));

    int n_pass = 0, n_total = 0;
    logic [11:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic got(input logic [11:0] tk);
        if (exp_q.size() == 0) check("unexpected_bus_token", {52'h0, tk}, 64'hFFFF);
        else check("bus_token", {52'h0, tk}, {52'h0, exp_q.pop_front()});
    endtask

    // Slave / bus monitor state
    logic       mon_en = 1'b0, scl_p = 1'b1, sda_p = 1'b1;
    logic       busy = 1'b0, rd_mode = 1'b0, rd_pend = 1'b0, addressed = 1'b0, master_ack = 1'b0;
    logic [7:0] shreg = '0, txb = '0;
    logic [15:0] ptr = '0;
    logic [7:0] smem [256];
    int         rises = 0, byte_i = 0, abytes = 1;

    always @(negedge clk) begin
        if (mon_en) begin
            if (scl_p && scl_bus && sda_p && !sda_bus) begin
                got(busy ? TK_RSTART : TK_START);
                busy = 1'b1; rises = 0; byte_i = 0; rd_mode = 1'b0; rd_pend = 1'b0;
                addressed = 1'b0; slave_low = 1'b0;
            end else if (scl_p && scl_bus && !sda_p && sda_bus) begin
                got(TK_STOP);
                busy = 1'b0; rd_mode = 1'b0; slave_low = 1'b0;
            end else if (!scl_p && scl_bus) begin
                if (rises < 8 && !rd_mode) shreg = {shreg[6:0], sda_bus};
                if (rises == 8 && rd_mode) begin
                    got(TK_MACK | {11'h0, sda_bus});
                    master_ack = !sda_bus;
                end
                rises++;
            end else if (scl_p && !scl_bus) begin
                if (rises == 8) begin
                    if (!rd_mode) begin
                        got({4'h0, shreg});
                        if (byte_i == 0) begin
                            addressed = (shreg[7:1] == SLV);
                            rd_pend   = shreg[0];
                        end else if (addressed && byte_i <= abytes) begin
                            ptr = {ptr[7:0], shreg};
                        end else if (addressed) begin
                            smem[ptr[7:0]] = shreg;
                            ptr++;
                        end
                        slave_low = addressed;
                    end else begin
                        slave_low = 1'b0;
                    end
                end else if (rises == 9) begin
                    rises = 0; byte_i++; slave_low = 1'b0;
                    if (addressed && rd_pend && (!rd_mode || master_ack)) begin
                        rd_mode   = 1'b1;
                        txb       = smem[ptr[7:0]];
                        ptr++;
                        slave_low = !txb[7];
                    end
                end else if (rd_mode && rises >= 1 && rises <= 7) begin
                    txb       = txb << 1;
                    slave_low = !txb[7];
                end
            end
        end
        scl_p = scl_bus;
        sda_p = sda_bus;
    end

    task automatic run_cmd(input logic use16, input logic is_rd, input logic [6:0] d,
                           input logic [15:0] m, input logic [2:0] l, input logic [31:0] wd,
                           input int exp_lat, input logic exp_err, input string tag,
                           input logic pulse_ce);
        int cnt;
        @(negedge clk);
        dev = d; mem8 = m[7:0]; mem16 = m; len = l; wdata = wd;
        wren = !is_rd; rden = is_rd;
        if (use16) ce16 = 1'b1; else ce8 = 1'b1;
        @(negedge clk);
        ce8 = 1'b0; ce16 = 1'b0;
        check({tag, "_ready_drop"}, use16 ? ready16 : ready8, 0);
        check({tag, "_error_clear"}, use16 ? error16 : error8, 0);
        cnt = 0;
        while (!(use16 ? done16 : done8) && cnt < 4000) begin
            @(negedge clk);
            cnt++;
            ce16 = pulse_ce && (cnt == 50 || cnt == 200);
        end
        ce16 = 1'b0;
        check({tag, "_latency"}, cnt, exp_lat);
        check({tag, "_error"}, use16 ? error16 : error8, {63'h0, exp_err});
        check({tag, "_ready"}, use16 ? ready16 : ready8, 1);
        check({tag, "_tokens_left"}, exp_q.size(), 0);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, use16 ? done16 : done8, 0);
    endtask

    initial begin
        logic seen_done;
        for (int i = 0; i < 256; i++) smem[i] = 8'h00;
        smem[8'h10] = 8'h10;
        smem[8'h11] = 8'h11;

        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready", ready8, 1);
        check("reset_scl", scl8, 1);
        check("reset_rdata", rdata8, 0);
        reset = 1'b1;
        mon_en = 1'b1;

        seen_done = 1'b0;
        repeat (500) begin
            @(negedge clk);
            if (done8 || done16) seen_done = 1'b1;
        end
        check("idle_no_done", seen_done, 0);
        check("idle_ready", ready8 & ready16, 1);
        check("idle_scl", scl_bus, 1);
        check("idle_sda_oe", sda_oe8 | sda_oe16, 0);

        // Single-byte write
        exp_q.push_back(TK_START); exp_q.push_back(12'h002); exp_q.push_back(12'h005);
        exp_q.push_back(12'h0A5);  exp_q.push_back(TK_STOP);
        run_cmd(1'b0, 1'b0, 7'h01, 16'h0005, 3'd1, 32'h0000_00A5, 232, 1'b0, "wr1", 1'b0);
        check("wr1_slave_mem", smem[8'h05], 8'hA5);

        // Two-byte read through repeated START
        exp_q.push_back(TK_START); exp_q.push_back(12'h002); exp_q.push_back(12'h010);
        exp_q.push_back(TK_RSTART); exp_q.push_back(12'h003);
        exp_q.push_back(TK_MACK | 12'h000); exp_q.push_back(TK_MACK | 12'h001);
        exp_q.push_back(TK_STOP);
        run_cmd(1'b0, 1'b1, 7'h01, 16'h0010, 3'd2, 32'h0, 384, 1'b0, "rd2", 1'b0);
        check("rd2_rdata", rdata8[15:0], 16'h1110);

        // No slave at this address: NACK on the device byte
        exp_q.push_back(TK_START); exp_q.push_back(12'h0AA); exp_q.push_back(TK_STOP);
        run_cmd(1'b0, 1'b0, 7'h55, 16'h0007, 3'd1, 32'h0000_0077, 88, 1'b1, "nack", 1'b0);

        // Illegal commands: both directions, then zero length
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            dev = 7'h01; mem8 = 8'h30; wdata = 32'h0;
            wren = 1'b1; rden = (k == 0); len = (k == 0) ? 3'd1 : 3'd0;
            ce8 = 1'b1;
            @(negedge clk);
            ce8 = 1'b0;
            check("illegal_done", done8, 1);
            check("illegal_error", error8, 1);
            check("illegal_ready", ready8, 1);
            check("illegal_scl", scl8, 1);
            @(negedge clk);
            check("illegal_done_drop", done8, 0);
            check("illegal_scl_held", scl8, 1);
        end

        // Legal write clears the error
        exp_q.push_back(TK_START); exp_q.push_back(12'h002); exp_q.push_back(12'h020);
        exp_q.push_back(12'h011); exp_q.push_back(12'h022); exp_q.push_back(12'h033);
        exp_q.push_back(TK_STOP);
        run_cmd(1'b0, 1'b0, 7'h01, 16'h0020, 3'd3, 32'h0033_2211, 376, 1'b0, "wr3", 1'b0);
        check("wr3_slave_mem", {smem[8'h22], smem[8'h21], smem[8'h20]}, 24'h332211);

        // Two-byte memory address, full burst, with ce pulses while busy
        abytes = 2;
        exp_q.push_back(TK_START); exp_q.push_back(12'h002); exp_q.push_back(12'h001);
        exp_q.push_back(12'h023); exp_q.push_back(12'h0AA); exp_q.push_back(12'h0BB);
        exp_q.push_back(12'h0CC); exp_q.push_back(12'h0DD); exp_q.push_back(TK_STOP);
        run_cmd(1'b1, 1'b0, 7'h01, 16'h0123, 3'd4, 32'hDDCC_BBAA, 520, 1'b0, "wr16", 1'b1);
        check("wr16_slave_mem", {smem[8'h26], smem[8'h25], smem[8'h24], smem[8'h23]}, 32'hDDCCBBAA);
        abytes = 1;

        // Reset in the middle of the device byte
        mon_en = 1'b0;
        @(negedge clk);
        dev = 7'h01; mem8 = 8'h40; len = 3'd1; wdata = 32'h0; wren = 1'b1; rden = 1'b0;
        ce8 = 1'b1;
        @(negedge clk);
        ce8 = 1'b0;
        repeat (30) @(negedge clk);
        check("mid_dev_busy", ready8, 0);
        #2 reset = 1'b0;
        #1;
        check("abort_scl", scl8, 1);
        check("abort_sda_oe", sda_oe8, 0);
        check("abort_ready", ready8, 1);
        @(posedge clk);
        #1;
        check("abort_scl_edge", scl8, 1);
        check("abort_ready_edge", ready8, 1);
        check("abort_done_edge", done8, 0);
        @(negedge clk);
        reset = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/i2c_burst_master.md
Name: i2c_burst_master

Overview:
- Parametrised next-generation I2C master for the APB-I2C subsystem.
- Accepts one command (device address, memory address, burst length, direction) from the APB-side bus and runs it on SCL/SDA.
- Adds multi-byte bursts, multi-byte memory addresses and repeated-START reads.
- NACKs are reported as errors; they do not stall the block. Runs on the system clock (8x SCL by default).

Parameters:
- DEV_ADDR_W, 7, device address width in bits; fixed at 7.
- MEM_ADDR_W, 8, memory address width in bits; multiple of 8. A = MEM_ADDR_W/8 address bytes.
- MAX_BURST, 4, maximum bytes per command (1..16).
- CLK_DIV, 8, clk cycles per SCL bit slot; even and >= 4.
- LEN_W, $clog2(MAX_BURST+1), width of the len field.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- ce  in  1  command valid
- wren  in  1  write command
- rden  in  1  read command
- dev_addr  in  DEV_ADDR_W  7-bit slave address
- mem_addr  in  MEM_ADDR_W  start memory address
- len  in  LEN_W  byte count
- wdata  in  8*MAX_BURST  write bytes; byte k is bits [8k+7:8k]
- rdata  out  8*MAX_BURST  read bytes, same packing
- ready  out  1  idle, command can be accepted
- done  out  1  one-cycle completion pulse
- error  out  1  last command failed
- SCL  out  1  I2C clock
- sda_oe  out  1  1 drives SDA low; 0 releases SDA (open drain)
- sda_in  in  1  sampled SDA line

Behaviour:
- Reset values (asserted at any time): ready=1, done=0, error=0, rdata=0, SCL=1, sda_oe=0, FSM=IDLE, counters=0.
- Reset mid-transfer aborts immediately; no STOP is generated.

Command acceptance:
- Accept on the rising clk where ce & ready.
- Latch dev_addr, mem_addr, len, wdata and the direction. ready drops the next cycle.
- error clears on each accept.
- Illegal command: wren==rden, len==0, or len>MAX_BURST.
  - error=1, no bus activity.
  - done pulses the following cycle; ready stays 1.
- ce while busy is ignored.

Bit slot timing:
- Each slot is CLK_DIV cycles, phase p = 0..CLK_DIV-1.
- Data slot: SCL=0 for p < CLK_DIV/2, SCL=1 otherwise. sda_oe updates at p==0. sda_in is sampled at p==3*CLK_DIV/4.
- START: SCL=1 for the whole slot; SDA released, then driven low at p==CLK_DIV/2.
- RSTART: first half SCL=0 with SDA released; second half SCL=1; SDA driven low at p==3*CLK_DIV/4.
- STOP: first half SCL=0 with SDA low; second half SCL=1; SDA released at p==3*CLK_DIV/4.
- Clock stretching is not supported.

FSM (bytes are sent MSB first):
- IDLE -> START -> DEV (8 slots).
  - Write command: DEV sends {dev_addr, 0}.
  - Read command: DEV sends {dev_addr, 0} (dummy write that sets the pointer).
- DEV -> DEV_ACK -> MADDR (8 slots) -> MADDR_ACK, repeated A times, MSB byte first.
- Write: WBYTE (8) -> WACK, repeated len times starting at byte 0 -> STOP -> IDLE.
- Read: RSTART -> DEVR ({dev_addr, 1}) -> DEVR_ACK -> RBYTE (8 slots, sda_oe=0) -> MACK, repeated len times -> STOP -> IDLE.
  - MACK drives ACK (low) after every byte except the last, which gets NACK (released).
  - Each read byte is written into rdata byte k at the end of its MACK slot.
- Any slave ACK slot sampling sda_in=1 (NACK):
  - error=1 and the FSM goes straight to STOP.
  - rdata bytes not yet received keep their previous values.
- done pulses and ready=1 on the cycle after the STOP slot ends.

Latency from accept to done, in slots (x CLK_DIV cycles):
- Write: 11 + 9A + 9*len.
- Read: 21 + 9A + 9*len.
- With A=1, CLK_DIV=8: write len=1 is 29 slots = 232 cycles; read len=2 is 48 slots = 384 cycles.

Test Plan:
- Reset release, no ce -> ready=1, SCL=1, sda_oe=0, done never pulses over 500 cycles; assert reset mid-DEV -> SCL=1, sda_oe=0, ready=1 next edge.
- Write dev=0x01, mem=0x05, len=1, wdata[7:0]=0xA5, slave model ACKs -> SDA bytes 0x02, 0x05, 0xA5 then STOP; done exactly 232 cycles after accept; error=0; model memory[5]=0xA5.
- Read dev=0x01, mem=0x10, len=2, model holds 0x10,0x11 -> sequence START,0x02,0x10,RSTART,0x03; MACK = ACK then NACK; rdata[15:0]=0x1110; done at 384 cycles.
- Write to dev=0x55 with no slave present (all ACK slots sample 1) -> STOP immediately after DEV_ACK; error=1; done pulse; no data slots driven.
- Illegal commands wren=rden=1, and len=0 -> error=1, done next cycle, SCL held 1 throughout; then a legal command clears error.
- MEM_ADDR_W=16, MAX_BURST=4 write mem=0x0123 len=4 -> address bytes 0x01, 0x23, four data ACKs, done at (11+18+36)*8=520 cycles; ce pulses during the transfer are ignored.
